// File: rtl/cmd_fifo_if.sv
// Handshake bundle between the cube-move command producer/consumer and cmd_fifo.
// The FIFO takes the slave modport; the side that drives requests takes master.
interface cmd_fifo_if #(
   parameter int DATA_W     = 9,
   parameter int DEPTH_LOG2 = 3
);
   logic                  wr_en;
   logic [DATA_W-1:0]     d_in;
   logic                  rd_en;
   logic [DATA_W-1:0]     d_out;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   count;
   logic                  err_clr;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, d_in, rd_en, err_clr,
      input  d_out, full, empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, d_in, rd_en, err_clr,
      output d_out, full, empty, count, overflow, underflow
   );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for 9-bit cube-move command words with registered read data.
// Define CMD_FIFO_ERR_EN to build the sticky overflow/underflow debug flags.
module cmd_fifo #(
   parameter int DATA_W     = 9,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic          i_clock,
   input  logic          i_reset,
   cmd_fifo_if.slave     bus
);

   localparam int unsigned          DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [DATA_W-1:0]     r_dout;

   logic w_full;
   logic w_empty;
   logic w_wr_acc;
   logic w_rd_acc;

   // Acceptance uses the pre-edge flags, so a full FIFO rejects a write even
   // when a read is accepted in the same cycle (and symmetrically for empty).
   assign w_full   = (r_count == COUNT_MAX);
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = bus.wr_en && !w_full;
   assign w_rd_acc = bus.rd_en && !w_empty;

   // NOTE: storage has no reset; entries are only read after being written,
   // and leaving it out keeps the array mappable onto plain RAM/LUT-RAM.
   always_ff @(posedge i_clock) begin
      if (w_wr_acc) begin
         r_mem[r_wptr] <= bus.d_in;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
         if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else begin
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_dout <= '0;
      end else if (w_rd_acc) begin
         r_dout <= r_mem[r_rptr];
      end
   end

   assign bus.d_out = r_dout;
   assign bus.full  = w_full;
   assign bus.empty = w_empty;
   assign bus.count = r_count;

`ifdef CMD_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // A new error event wins over a clear arriving in the same cycle.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.wr_en && w_full)   r_overflow <= 1'b1;
         else if (bus.err_clr)      r_overflow <= 1'b0;

         if (bus.rd_en && w_empty)  r_underflow <= 1'b1;
         else if (bus.err_clr)      r_underflow <= 1'b0;
      end
   end

   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr = bus.err_clr;
   assign bus.overflow     = 1'b0;
   assign bus.underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_fifo.sv
// Self-checking bench for cmd_fifo: directed test-plan sequences followed by
// randomized traffic, compared every cycle against a queue-based model.
module tb_cmd_fifo;

`ifdef CMD_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int DEPTH = 8;

   logic clk;
   logic rst;

   cmd_fifo_if #(.DATA_W(9), .DEPTH_LOG2(3)) bus ();

   cmd_fifo #(.DATA_W(9), .DEPTH_LOG2(3)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: contents as a queue, plus the last word read out.
   logic [8:0] m_q [$];
   logic [8:0] m_dout;
   bit         m_ovf;
   bit         m_unf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endfunction

   // Advance the model by one rising edge using the currently driven inputs.
   function automatic void model_step();
      int  n;
      bit  wr_ok;
      bit  rd_ok;
      n     = m_q.size();
      wr_ok = bus.wr_en && (n < DEPTH);
      rd_ok = bus.rd_en && (n > 0);
      if (ERR_EN) begin
         if (bus.wr_en && n == DEPTH) m_ovf = 1'b1;
         else if (bus.err_clr)        m_ovf = 1'b0;
         if (bus.rd_en && n == 0)     m_unf = 1'b1;
         else if (bus.err_clr)        m_unf = 1'b0;
      end
      if (rd_ok) m_dout = m_q.pop_front();
      if (wr_ok) m_q.push_back(bus.d_in);
   endfunction

   task automatic compare();
      check("count",     32'(bus.count),     32'(m_q.size()));
      check("empty",     32'(bus.empty),     32'(m_q.size() == 0));
      check("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
      check("d_out",     32'(bus.d_out),     32'(m_dout));
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
      check("underflow", 32'(bus.underflow), 32'(m_unf));
   endtask

   // Drive one cycle of stimulus, clock it, and compare just after the edge.
   task automatic cycle(input logic we, input logic [8:0] d, input logic re, input logic ec);
      bus.wr_en   = we;
      bus.d_in    = d;
      bus.rd_en   = re;
      bus.err_clr = ec;
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      cycle(1'b0, 9'h000, 1'b0, 1'b0);
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.d_in    = '0;
      bus.rd_en   = 1'b0;
      bus.err_clr = 1'b0;
      rst         = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare();
      rst = 1'b0;

      // Reset then idle.
      repeat (10) idle();
      check("idle_count", 32'(bus.count), 32'd0);
      check("idle_empty", 32'(bus.empty), 32'd1);
      check("idle_dout",  32'(bus.d_out), 32'h000);

      // Three writes then three reads.
      cycle(1'b1, 9'h00A, 1'b0, 1'b0);
      check("w1_count", 32'(bus.count), 32'd1);
      cycle(1'b1, 9'h00C, 1'b0, 1'b0);
      check("w2_count", 32'(bus.count), 32'd2);
      cycle(1'b1, 9'h00E, 1'b0, 1'b0);
      check("w3_count", 32'(bus.count), 32'd3);
      cycle(1'b0, 9'h000, 1'b1, 1'b0);
      check("r1_dout", 32'(bus.d_out), 32'h00A);
      check("r1_count", 32'(bus.count), 32'd2);
      cycle(1'b0, 9'h000, 1'b1, 1'b0);
      check("r2_dout", 32'(bus.d_out), 32'h00C);
      cycle(1'b0, 9'h000, 1'b1, 1'b0);
      check("r3_dout", 32'(bus.d_out), 32'h00E);
      check("r3_empty", 32'(bus.empty), 32'd1);

      // Fill, overflow attempt, drain.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 9'(9'h100 + i), 1'b0, 1'b0);
      cycle(1'b1, 9'h1FF, 1'b0, 1'b0);
      check("fill_full",  32'(bus.full),     32'd1);
      check("fill_count", 32'(bus.count),    32'd8);
      check("fill_ovf",   32'(bus.overflow), 32'(ERR_EN));
      idle();
      check("ovf_sticky", 32'(bus.overflow), 32'(ERR_EN));
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 9'h000, 1'b1, 1'b0);
         check("drain_dout", 32'(bus.d_out), 32'(9'h100 + i));
      end
      cycle(1'b0, 9'h000, 1'b0, 1'b1);
      check("ovf_clr", 32'(bus.overflow), 32'd0);

      // Read on empty with a simultaneous write.
      cycle(1'b1, 9'h00C, 1'b1, 1'b0);
      check("rde_dout",  32'(bus.d_out),     32'h107);
      check("rde_count", 32'(bus.count),     32'd1);
      check("rde_unf",   32'(bus.underflow), 32'(ERR_EN));
      cycle(1'b0, 9'h000, 1'b0, 1'b1);

      // Steady count=3 with simultaneous read/write for 20 cycles.
      cycle(1'b1, 9'h011, 1'b0, 1'b0);
      cycle(1'b1, 9'h012, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 9'($urandom_range(0, 511)), 1'b1, 1'b0);
         check("steady_count", 32'(bus.count), 32'd3);
      end

      // Mid-stream reset at count=5, then first word after reset.
      cycle(1'b1, 9'h021, 1'b0, 1'b0);
      cycle(1'b1, 9'h022, 1'b0, 1'b0);
      check("pre_rst_count", 32'(bus.count), 32'd5);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_dout",  32'(bus.d_out), 32'h000);
      compare();
      @(posedge clk);
      #1;
      compare();
      rst = 1'b0;
      cycle(1'b1, 9'h00E, 1'b0, 1'b0);
      cycle(1'b0, 9'h000, 1'b1, 1'b0);
      check("post_rst_dout", 32'(bus.d_out), 32'h00E);

      // Randomized traffic with a slowly drifting write/read bias.
      for (int i = 0; i < 3000; i++) begin
         int wp;
         wp = ((i / 200) % 2 == 0) ? 70 : 30;
         cycle(1'($urandom_range(0, 99) < wp),
               9'($urandom_range(0, 511)),
               1'($urandom_range(0, 99) < (100 - wp)),
               1'($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
